mem_rd_stream: RTL and testbench

- Read-side master for the team's simple dual-port block memory.
- Takes a start command with a base address and a word count.
- Drives the memory read port (enable, address) against its 1-cycle registered read latency.
- Presents the words as a valid/ready stream with a last flag, e.g. for pattern playback into the BERT transmit path.
- Sustains one word per cycle under no backpressure; never drops or duplicates a word under backpressure.

---
 rtl/mem_rd_stream_pkg.sv | 15 +
 rtl/mem_rd_stream_skid_fifo2.sv | 48 ++++
 rtl/mem_rd_stream.sv | 162 ++++++++++++++++
 tb/tb_mem_rd_stream.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_rd_stream_pkg.sv
// Shared types and helpers for the mem_rd_stream block-memory read streamer.
package mem_rd_stream_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN
  } state_t;

  // Address increment that wraps at the memory depth (DEPTH need not be a power of two).
  function automatic int unsigned wrap_inc(input int unsigned a, input int unsigned depth);
    return (a + 1 >= depth) ? 0 : a + 1;
  endfunction

endpackage

// File: rtl/mem_rd_stream_skid_fifo2.sv
// Two-entry synchronous FIFO with async reset; push and pop may coincide, even when full.
module skid_fifo2 #(
  parameter int unsigned W = 33
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_push,
  input  logic [W-1:0] i_din,
  input  logic         i_pop,
  output logic [W-1:0] o_dout,
  output logic [1:0]   o_occ
);

  logic [W-1:0] r_mem [2];
  logic         r_wr;
  logic         r_rd;
  logic [1:0]   r_occ;
  logic         w_pop;
  logic         w_push;

  assign w_pop  = i_pop && (r_occ != 2'd0);
  assign w_push = i_push && ((r_occ != 2'd2) || w_pop);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mem[0] <= '0;
      r_mem[1] <= '0;
      r_wr     <= 1'b0;
      r_rd     <= 1'b0;
      r_occ    <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr] <= i_din;
        r_wr        <= ~r_wr;
      end
      if (w_pop) r_rd <= ~r_rd;
      case ({w_push, w_pop})
        2'b10:   r_occ <= r_occ + 2'd1;
        2'b01:   r_occ <= r_occ - 2'd1;
        default: r_occ <= r_occ;
      endcase
    end
  end

  assign o_dout = r_mem[r_rd];
  assign o_occ  = r_occ;

endmodule

// File: rtl/mem_rd_stream.sv
// Streams len words from a 1-cycle-latency block memory as valid/ready with last.
// Optional macro MEM_RD_STREAM_LOOP_EN: repeat the pass until stop, adding the stop input.
module mem_rd_stream
  import mem_rd_stream_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 512,
  parameter int unsigned LW    = $clog2(DEPTH) + 1,
  localparam int unsigned AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [AW-1:0]    base_addr,
  input  logic [LW-1:0]    len,
`ifdef MEM_RD_STREAM_LOOP_EN
  input  logic             stop,
`endif
  output logic             busy,
  output logic             done,
  output logic             mem_en,
  output logic [AW-1:0]    mem_addr,
  input  logic [WIDTH-1:0] mem_dout,
  output logic [WIDTH-1:0] m_data,
  output logic             m_valid,
  input  logic             m_ready,
  output logic             m_last
);

  typedef struct packed {
    logic             last;
    logic [WIDTH-1:0] data;
  } entry_t;

  state_t        r_state, w_state_nxt;
  logic [AW-1:0] r_addr, w_addr_nxt, r_base;
  logic [LW-1:0] r_len, r_issued, w_issued_nxt;
  logic          r_inflight, r_inflight_last;
  logic          r_done, w_done_nxt;
  logic [1:0]    w_occ;
  entry_t        w_head, w_push_entry;
  logic          w_pop, w_issue, w_issue_last, w_final_pop, w_stop;

  assign w_pop        = m_valid & m_ready;
  // Issue only if the word can still land in the FIFO, counting this cycle's pop.
  assign w_issue      = (r_state == RUN) &&
                        (({1'b0, w_occ} + {2'b00, r_inflight}) < (3'd2 + {2'b00, w_pop}));
  assign w_issue_last = (r_issued == r_len - LW'(1));
  // Final word is the only one left anywhere in the pipe when it is popped in DRAIN.
  assign w_final_pop  = (r_state == DRAIN) && w_pop && w_head.last &&
                        (w_occ == 2'd1) && !r_inflight;

`ifdef MEM_RD_STREAM_LOOP_EN
  logic r_stop_req, w_stop_req_nxt;
  assign w_stop = r_stop_req | stop;
`else
  assign w_stop = 1'b1;
`endif

  always_comb begin
    w_state_nxt  = r_state;
    w_addr_nxt   = r_addr;
    w_issued_nxt = r_issued;
    w_done_nxt   = 1'b0;
`ifdef MEM_RD_STREAM_LOOP_EN
    w_stop_req_nxt = r_stop_req;
`endif
    case (r_state)
      IDLE: begin
        if (start) begin
          if (len != '0) begin
            w_state_nxt  = RUN;
            w_addr_nxt   = base_addr;
            w_issued_nxt = '0;
`ifdef MEM_RD_STREAM_LOOP_EN
            w_stop_req_nxt = 1'b0;
`endif
          end else begin
            w_done_nxt = 1'b1;
          end
        end
      end
      RUN: begin
`ifdef MEM_RD_STREAM_LOOP_EN
        if (stop) w_stop_req_nxt = 1'b1;
`endif
        if (w_issue) begin
          w_addr_nxt   = AW'(wrap_inc(32'(r_addr), DEPTH));
          w_issued_nxt = r_issued + LW'(1);
          if (w_issue_last) begin
            if (w_stop) begin
              w_state_nxt = DRAIN;
            end else begin
              w_addr_nxt   = r_base;
              w_issued_nxt = '0;
            end
          end
        end
      end
      DRAIN: begin
        if (w_final_pop) begin
          w_state_nxt = IDLE;
          w_done_nxt  = 1'b1;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state         <= IDLE;
      r_addr          <= '0;
      r_base          <= '0;
      r_len           <= '0;
      r_issued        <= '0;
      r_inflight      <= 1'b0;
      r_inflight_last <= 1'b0;
      r_done          <= 1'b0;
`ifdef MEM_RD_STREAM_LOOP_EN
      r_stop_req      <= 1'b0;
`endif
    end else begin
      r_state         <= w_state_nxt;
      r_addr          <= w_addr_nxt;
      r_issued        <= w_issued_nxt;
      r_inflight      <= w_issue;
      r_inflight_last <= w_issue & w_issue_last;
      r_done          <= w_done_nxt;
`ifdef MEM_RD_STREAM_LOOP_EN
      r_stop_req      <= w_stop_req_nxt;
`endif
      if (r_state == IDLE && start) begin
        r_base <= base_addr;
        r_len  <= len;
      end
    end
  end

  assign w_push_entry = '{last: r_inflight_last, data: mem_dout};

  skid_fifo2 #(
    .W($bits(entry_t))
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .i_push(r_inflight),
    .i_din (w_push_entry),
    .i_pop (w_pop),
    .o_dout(w_head),
    .o_occ (w_occ)
  );

  assign busy     = (r_state != IDLE);
  assign done     = r_done;
  assign mem_en   = w_issue;
  assign mem_addr = r_addr;
  assign m_valid  = (w_occ != 2'd0);
  assign m_data   = w_head.data;
  assign m_last   = w_head.last;

endmodule

// File: tb/tb_mem_rd_stream.sv
module tb_mem_rd_stream;
  localparam int unsigned WIDTH = 32;
  localparam int unsigned DEPTH = 512;
  localparam int unsigned AW    = 9;
  localparam int unsigned LW    = 10;
  localparam int unsigned INF   = 32'hFFFF_FFFF;

  logic             clk = 1'b0;
  logic             rst, start, m_ready;
  logic [AW-1:0]    base_addr;
  logic [LW-1:0]    len;
  logic             busy, done, mem_en, m_valid, m_last;
  logic [AW-1:0]    mem_addr;
  logic [WIDTH-1:0] mem_dout, m_data;
`ifdef MEM_RD_STREAM_LOOP_EN
  logic             stop;
`endif

  logic [WIDTH-1:0] mem [DEPTH];

  always #5 clk = ~clk;
  always @(posedge clk) if (mem_en) mem_dout <= mem[mem_addr];

  mem_rd_stream #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .base_addr(base_addr),
    .len      (len),
`ifdef MEM_RD_STREAM_LOOP_EN
    .stop     (stop),
`endif
    .busy     (busy),
    .done     (done),
    .mem_en   (mem_en),
    .mem_addr (mem_addr),
    .mem_dout (mem_dout),
    .m_data   (m_data),
    .m_valid  (m_valid),
    .m_ready  (m_ready),
    .m_last   (m_last)
  );

  int unsigned n_checks = 0, n_pass = 0;

  task automatic chk(input string name, input bit ok);
    n_checks++;
    if (ok) n_pass++;
    else $display("FAIL %s at t=%0t", name, $time);
  endtask

  bit               m_busy = 0, done_due = 0, stopped = 0, prev_stall = 0;
  int unsigned      m_base, m_len, total, issue_idx, pop_idx, cyc = 0, done_cyc = 0;
  logic [WIDTH-1:0] prev_data;
  logic             prev_last;
  logic [WIDTH-1:0] obs_data[$];
  logic             obs_last[$];
  logic [AW-1:0]    obs_addr[$];
  int unsigned      obs_pop_cyc[$], obs_en_cyc[$];

  function automatic logic [AW-1:0] exp_addr(input int unsigned i);
    return AW'((m_base + i % m_len) % DEPTH);
  endfunction

  function automatic logic exp_last(input int unsigned i);
    return (i % m_len) == m_len - 1;
  endfunction

  always @(negedge clk) begin : cmp
    bit nb, nd;
    int unsigned n;
    cyc++;
    if (rst) begin
      chk("rst_busy", busy === 1'b0);
      chk("rst_done", done === 1'b0);
      chk("rst_mem_en", mem_en === 1'b0);
      chk("rst_mem_addr", mem_addr === '0);
      chk("rst_m_valid", m_valid === 1'b0);
      chk("rst_m_last", m_last === 1'b0);
      chk("rst_m_data", m_data === '0);
      m_busy = 0; done_due = 0; prev_stall = 0;
    end else begin
      chk("done", done === done_due);
      chk("busy", busy === m_busy);
      chk("occ_le2", u_dut.u_fifo.o_occ <= 2'd2);
      if (done) done_cyc = cyc;
      nd = 0;
      nb = m_busy;
      if (mem_en) begin
        obs_addr.push_back(mem_addr);
        obs_en_cyc.push_back(cyc);
        if (!m_busy || issue_idx >= total) chk("spurious_mem_en", 1'b0);
        else chk("mem_addr", mem_addr === exp_addr(issue_idx));
        issue_idx++;
      end
      if (prev_stall) begin
        chk("stall_valid", m_valid === 1'b1);
        chk("stall_data", m_data === prev_data);
        chk("stall_last", m_last === prev_last);
      end
      if (m_valid && m_ready) begin
        obs_data.push_back(m_data);
        obs_last.push_back(m_last);
        obs_pop_cyc.push_back(cyc);
        if (!m_busy || pop_idx >= total) chk("spurious_word", 1'b0);
        else begin
          chk("m_data", m_data === mem[exp_addr(pop_idx)]);
          chk("m_last", m_last === exp_last(pop_idx));
          if (pop_idx == total - 1) begin nd = 1; nb = 0; end
        end
        pop_idx++;
      end
      prev_stall = m_valid && !m_ready;
      prev_data  = m_data;
      prev_last  = m_last;
`ifdef MEM_RD_STREAM_LOOP_EN
      if (stop && m_busy && !stopped && total == INF) begin
        stopped = 1;
        n = issue_idx;
        if (mem_en && n % m_len == 0) total = n;
        else total = (n / m_len + 1) * m_len;
      end
`endif
      if (start && !m_busy) begin
        m_base = base_addr; m_len = len; issue_idx = 0; pop_idx = 0; stopped = 0;
`ifdef MEM_RD_STREAM_LOOP_EN
        total = (len == 0) ? 0 : INF;
`else
        total = len;
`endif
        if (len == 0) nd = 1; else nb = 1;
      end
      done_due = nd;
      m_busy   = nb;
    end
  end

  task automatic clear_obs();
    obs_data.delete(); obs_last.delete(); obs_addr.delete();
    obs_pop_cyc.delete(); obs_en_cyc.delete();
  endtask

  task automatic do_start(input int unsigned b, input int unsigned l, input bit with_stop);
    @(posedge clk); #1;
    start = 1; base_addr = AW'(b); len = LW'(l);
    @(posedge clk); #1;
    start = 0;
`ifdef MEM_RD_STREAM_LOOP_EN
    if (with_stop && l != 0) begin
      stop = 1;
      @(posedge clk); #1;
      stop = 0;
    end
`else
    if (with_stop) begin end
`endif
  endtask

  task automatic wait_done(input bit rnd, input int unsigned budget, input string nm);
    bit got = 0;
    for (int unsigned i = 0; i < budget && !got; i++) begin
      m_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      @(negedge clk);
      got = done;
      @(posedge clk); #1;
    end
    chk({nm, "_done_seen"}, got === 1'b1);
    m_ready = 1;
  endtask

  task automatic wait_words(input int unsigned k, input int unsigned budget);
    for (int unsigned i = 0; i < budget && obs_data.size() < k; i++) begin
      @(negedge clk); #1;
    end
    chk("wait_words", obs_data.size() >= k);
  endtask

  initial begin
    rst = 1; start = 0; base_addr = '0; len = '0; m_ready = 1;
`ifdef MEM_RD_STREAM_LOOP_EN
    stop = 0;
`endif
    for (int a = 0; a < int'(DEPTH); a++) mem[a] = WIDTH'(a);
    repeat (3) @(posedge clk);
    #1 rst = 0;

    clear_obs();
    do_start(32'h010, 4, 1);
    wait_done(0, 40, "t1");
    chk("t1_count", obs_data.size() === 4);
    for (int i = 0; i < 4; i++) begin
      chk("t1_data", obs_data[i] === 32'h10 + i);
      chk("t1_addr", obs_addr[i] === AW'(32'h10 + i));
      chk("t1_last", obs_last[i] === (i == 3));
    end
    chk("t1_addr_consec", obs_en_cyc[3] - obs_en_cyc[0] === 3);
    chk("t1_data_consec", obs_pop_cyc[3] - obs_pop_cyc[0] === 3);
    chk("t1_first_latency", obs_pop_cyc[0] - obs_en_cyc[0] === 2);
    chk("t1_done_latency", done_cyc - obs_pop_cyc[3] === 1);

    clear_obs();
    do_start(32'h1FE, 4, 1);
    wait_done(0, 40, "wrap");
    chk("wrap_count", obs_data.size() === 4);
    chk("wrap_a0", obs_addr[0] === 9'h1FE);
    chk("wrap_a1", obs_addr[1] === 9'h1FF);
    chk("wrap_a2", obs_addr[2] === 9'h000);
    chk("wrap_a3", obs_addr[3] === 9'h001);
    chk("wrap_d2", obs_data[2] === 32'h000);

    clear_obs();
    do_start(32'h040, 8, 1);
    wait_done(1, 200, "bp");
    chk("bp_count", obs_data.size() === 8);
    for (int i = 0; i < 8; i++) chk("bp_data", obs_data[i] === 32'h40 + i);

    clear_obs();
    do_start(32'h055, 0, 1);
    wait_done(0, 4, "len0");
    repeat (3) @(posedge clk);
    chk("len0_no_read", obs_addr.size() === 0);

    clear_obs();
    do_start(32'h030, 8, 1);
    wait_words(3, 40);
    #2 rst = 1;
    #1;
    chk("mid_rst_busy", busy === 1'b0);
    chk("mid_rst_valid", m_valid === 1'b0);
    chk("mid_rst_mem_en", mem_en === 1'b0);
    chk("mid_rst_mem_addr", mem_addr === '0);
    chk("mid_rst_data", m_data === '0);
    @(posedge clk); @(posedge clk); #1 rst = 0;
    clear_obs();
    do_start(32'h100, 2, 1);
    wait_done(0, 40, "post_rst");
    chk("post_rst_count", obs_data.size() === 2);
    chk("post_rst_d0", obs_data[0] === 32'h100);
    chk("post_rst_d1", obs_data[1] === 32'h101);

`ifdef MEM_RD_STREAM_LOOP_EN
    clear_obs();
    do_start(32'h020, 3, 0);
    wait_words(3, 40);
    @(posedge clk); #1 stop = 1;
    @(posedge clk); #1 stop = 0;
    wait_done(0, 60, "loop");
    chk("loop_count", obs_data.size() === 6);
    for (int i = 0; i < 6; i++) begin
      chk("loop_data", obs_data[i] === 32'h20 + (i % 3));
      chk("loop_last", obs_last[i] === ((i % 3) == 2));
    end
`endif

    for (int a = 0; a < int'(DEPTH); a++) mem[a] = $urandom;
    for (int t = 0; t < 8; t++) begin
      int unsigned b, l;
      b = $urandom_range(0, DEPTH - 1);
      l = (t == 7) ? DEPTH : $urandom_range(1, 24);
      clear_obs();
      do_start(b, l, 1);
      wait_done(1, 4000, "rand");
      chk("rand_count", obs_data.size() === l);
    end

    repeat (3) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
